// File: rtl/adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, multi-cycle FSM
// with strobe/acknowledge handshakes on operand A, operand B and result Z.
module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0,
        ADD_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_e;

    localparam logic signed [9:0] EMIN  = -10'sd126;
    localparam logic signed [9:0] EMAX  = 10'sd128;
    localparam logic signed [9:0] EBIAS = 10'sd127;
    localparam logic [31:0]       QNAN  = 32'h7FC00000;

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d, z_q, z_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic              z_stb_q, z_stb_d;
    logic [26:0]       a_m_q, a_m_d, b_m_q, b_m_d;
    logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic              a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic [27:0]       sum_q, sum_d;
    logic [23:0]       z_m_q, z_m_d;
    logic              g_q, g_d, r_q, r_d, st_q, st_d;

    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]        z_bexp;

    // Significands are {hidden, mantissa[22:0], G, R, S}
    assign a_nan  = (a_e_q == EMAX) && (a_m_q[25:3] != 23'd0);
    assign b_nan  = (b_e_q == EMAX) && (b_m_q[25:3] != 23'd0);
    assign a_inf  = (a_e_q == EMAX) && (a_m_q[25:3] == 23'd0);
    assign b_inf  = (b_e_q == EMAX) && (b_m_q[25:3] == 23'd0);
    assign a_zero = (a_e_q == EMIN) && (a_m_q == 27'd0);
    assign b_zero = (b_e_q == EMIN) && (b_m_q == 27'd0);
    assign z_bexp = 8'(z_e_q + EBIAS);

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            a_m_q   <= '0;
            b_m_q   <= '0;
            a_e_q   <= '0;
            b_e_q   <= '0;
            z_e_q   <= '0;
            a_s_q   <= 1'b0;
            b_s_q   <= 1'b0;
            z_s_q   <= 1'b0;
            sum_q   <= '0;
            z_m_q   <= '0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
            a_m_q   <= a_m_d;
            b_m_q   <= b_m_d;
            a_e_q   <= a_e_d;
            b_e_q   <= b_e_d;
            z_e_q   <= z_e_d;
            a_s_q   <= a_s_d;
            b_s_q   <= b_s_d;
            z_s_q   <= z_s_d;
            sum_q   <= sum_d;
            z_m_q   <= z_m_d;
            g_q     <= g_d;
            r_q     <= r_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        a_ack_d = a_ack_q;
        b_ack_d = b_ack_q;
        z_stb_d = z_stb_q;
        a_m_d   = a_m_q;
        b_m_d   = b_m_q;
        a_e_d   = a_e_q;
        b_e_d   = b_e_q;
        z_e_d   = z_e_q;
        a_s_d   = a_s_q;
        b_s_d   = b_s_q;
        z_s_d   = z_s_q;
        sum_d   = sum_q;
        z_m_d   = z_m_q;
        g_d     = g_q;
        r_d     = r_q;
        st_d    = st_q;

        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_s_d = a_q[31];
                b_s_d = b_q[31];
                a_m_d = {(a_q[30:23] != 8'd0), a_q[22:0], 3'b000};
                b_m_d = {(b_q[30:23] != 8'd0), b_q[22:0], 3'b000};
                a_e_d = (a_q[30:23] == 8'd0) ? EMIN
                      : $signed({2'b00, a_q[30:23]}) - EBIAS;
                b_e_d = (b_q[30:23] == 8'd0) ? EMIN
                      : $signed({2'b00, b_q[30:23]}) - EBIAS;
                state_d = SPECIAL;
            end
            SPECIAL: begin
                state_d = PUT_Z;
                if (a_nan || b_nan) begin
                    z_d = QNAN;
                end else if (a_inf && b_inf && (a_s_q != b_s_q)) begin
                    z_d = QNAN;
                end else if (a_inf) begin
                    z_d = {a_s_q, 8'hFF, 23'd0};
                end else if (b_inf) begin
                    z_d = {b_s_q, 8'hFF, 23'd0};
                end else if (a_zero && b_zero) begin
                    z_d = {a_s_q & b_s_q, 31'd0};
                end else if (a_zero) begin
                    z_d = b_q;
                end else if (b_zero) begin
                    z_d = a_q;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                // The shifted-out bit folds into the sticky position
                if (a_e_q > b_e_q) begin
                    b_e_d = b_e_q + 10'sd1;
                    b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
                end else if (a_e_q < b_e_q) begin
                    a_e_d = a_e_q + 10'sd1;
                    a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
                end else begin
                    state_d = ADD_0;
                end
            end
            ADD_0: begin
                z_e_d = a_e_q;
                if (a_s_q == b_s_q) begin
                    sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
                    z_s_d = a_s_q;
                end else if (a_m_q >= b_m_q) begin
                    sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
                    z_s_d = (a_m_q == b_m_q) ? 1'b0 : a_s_q;
                end else begin
                    sum_d = {1'b0, b_m_q} - {1'b0, a_m_q};
                    z_s_d = b_s_q;
                end
                state_d = ADD_1;
            end
            ADD_1: begin
                if (sum_q[27]) begin
                    z_m_d = sum_q[27:4];
                    g_d   = sum_q[3];
                    r_d   = sum_q[2];
                    st_d  = sum_q[1] | sum_q[0];
                    z_e_d = z_e_q + 10'sd1;
                end else begin
                    z_m_d = sum_q[26:3];
                    g_d   = sum_q[2];
                    r_d   = sum_q[1];
                    st_d  = sum_q[0];
                end
                state_d = NORM_1;
            end
            NORM_1: begin
                if (!z_m_q[23] && (z_e_q > EMIN)) begin
                    z_e_d = z_e_q - 10'sd1;
                    z_m_d = {z_m_q[22:0], g_q};
                    g_d   = r_q;
                    r_d   = 1'b0;
                end else begin
                    state_d = NORM_2;
                end
            end
            NORM_2: begin
                if (z_e_q < EMIN) begin
                    z_e_d = z_e_q + 10'sd1;
                    z_m_d = {1'b0, z_m_q[23:1]};
                    g_d   = z_m_q[0];
                    r_d   = g_q;
                    st_d  = st_q | r_q;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (g_q && (r_q || st_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    if (&z_m_q) begin
                        z_e_d = z_e_q + 10'sd1;
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                z_d = {z_s_q, z_bexp, z_m_q[22:0]};
                if ((z_e_q == EMIN) && !z_m_q[23]) begin
                    z_d[30:23] = 8'd0;
                end
                if (z_e_q > EBIAS) begin
                    z_d[30:0] = {8'hFF, 23'd0};
                end
                state_d = PUT_Z;
            end
            PUT_Z: begin
                z_stb_d = 1'b1;
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the binary32 adder: an exact wide-integer
// reference model feeds an expectation queue drained by a monitor.
module tb_adder;

    localparam int LIMIT = 2000;
    localparam int NRAND = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic        prev_stb = 1'b0;
    logic [31:0] held_z = '0;

    adder dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: no handshake within %0d cycles",
                 name, LIMIT);
    endtask

    // Operand magnitude as an integer multiple of 2^-149
    function automatic logic [299:0] mag_of(input logic [31:0] x);
        logic [299:0] m;
        int e;
        m = '0;
        m[22:0] = x[22:0];
        m[23] = (x[30:23] != 8'd0);
        e = (x[30:23] == 8'd0) ? 0 : int'(x[30:23]) - 1;
        return m << e;
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        logic [299:0] ma, mb, mag, kept, rem, half;
        logic [7:0]   fe;
        int           p, sh, fld;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if (a_inf && b_inf && (a[31] != b[31])) return 32'h7FC00000;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        ma = mag_of(a);
        mb = mag_of(b);
        if (a[31] == b[31]) begin
            mag = ma + mb;
            s = a[31];
        end else if (ma >= mb) begin
            mag = ma - mb;
            s = a[31];
        end else begin
            mag = mb - ma;
            s = b[31];
        end
        if (mag == '0) return 32'h00000000;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 24) return {s, mag[30:0]};
        sh = p - 23;
        kept = mag >> sh;
        rem = mag - (kept << sh);
        half = 300'd1 << (sh - 1);
        if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 1;
        if (kept[24]) begin
            kept = kept >> 1;
            sh++;
        end
        fld = sh + 1;
        if (fld >= 255) return {s, 8'hFF, 23'd0};
        fe = 8'(fld);
        return {s, fe, kept[22:0]};
    endfunction

    // Monitor: compare each newly presented result, then hold-stability
    always @(negedge clk) begin
        if (output_z_stb && !prev_stb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %08h, required none",
                         output_z);
            end else begin
                check("result", output_z, exp_q.pop_front());
            end
            held_z = output_z;
        end else if (output_z_stb && prev_stb) begin
            check("z_stable", output_z, held_z);
        end
        prev_stb = output_z_stb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expect_z);
        int n;
        exp_q.push_back(expect_z);
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < LIMIT) begin
            tick();
            n++;
        end
        if (!input_a_ack) timeout("a_ack");
        tick();
        input_a_stb = 1'b0;
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (!input_b_ack && n < LIMIT) begin
            tick();
            n++;
        end
        if (!input_b_ack) timeout("b_ack");
        tick();
        input_b_stb = 1'b0;
    endtask

    task automatic wait_z();
        int n;
        n = 0;
        while (!output_z_stb && n < LIMIT) begin
            tick();
            n++;
        end
        if (!output_z_stb) timeout("z_stb");
    endtask

    task automatic take();
        wait_z();
        output_z_ack = 1'b1;
        tick();
        output_z_ack = 1'b0;
        check("z_stb_drop", {31'd0, output_z_stb}, 32'd0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expect_z);
        send(a, b, expect_z);
        take();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        input_a = '0;
        input_b = '0;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        tick();
        tick();
        check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        check("rst_z", output_z, 32'd0);
        rst = 1'b0;
        tick();
        check("a_ack_rise", {31'd0, input_a_ack}, 32'd1);

        // Both strobes high together, result held without acknowledge
        exp_q.push_back(32'h41A71CE0);
        input_a = 32'hC14C51EC;
        input_b = 32'h4206A2EB;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        wait_z();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_z_stb", {31'd0, output_z_stb}, 32'd1);
            check("hold_a_ack", {31'd0, input_a_ack}, 32'd0);
            check("hold_b_ack", {31'd0, input_b_ack}, 32'd0);
        end
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        take();

        send(32'h3F800000, 32'h3F800000, 32'h40000000);
        take();
        tick();
        check("a_ack_after_z", {31'd0, input_a_ack}, 32'd1);

        run(32'h7F800000, 32'hFF800000, 32'h7FC00000);
        run(32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        run(32'h40400000, 32'hC0400000, 32'h00000000);
        run(32'h80000000, 32'h80000000, 32'h80000000);
        run(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run(32'h00000001, 32'h00000001, 32'h00000002);
        run(32'h3F800000, 32'h33800000, 32'h3F800000);
        run(32'h3F800000, 32'h00000000, 32'h3F800000);
        run(32'h00400000, 32'h80000000, 32'h00400000);

        // Reset in the middle of a long alignment
        send(32'h3F800000, 32'h0D800000, 32'h3F800000);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        check("mid_rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        check("mid_rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        check("mid_rst_z", output_z, 32'd0);
        tick();
        check("mid_rst_a_ack_rise", {31'd0, input_a_ack}, 32'd1);
        run(32'h3F800000, 32'h3F800000, 32'h40000000);

        for (int i = 0; i < NRAND; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2, 3: b[30:23] = a[30:23] + 8'($urandom_range(0, 4))
                                     - 8'd2;
                4: begin
                    a[30:23] = 8'($urandom_range(0, 2));
                    b[30:23] = 8'd0;
                end
                5: b = {~a[31], a[30:0]} ^ 32'($urandom_range(0, 3));
                6: b = {b[31], 31'd0};
                default: ;
            endcase
            run(a, b, ref_add(a, b));
        end

        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder.md
# adder

IEEE-754 single-precision floating-point adder with independent strobe/acknowledge handshakes on both operands and on the result. It accepts operand A, then operand B, and computes A+B with round-to-nearest-even through a multi-cycle state machine. It then holds the result until the consumer acknowledges it. It is the accumulation element of the matrix-multiplier datapath.

## Interface
- No parameters; the format is fixed at 32-bit binary32.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- input_a  in  32  operand A (binary32).
- input_a_stb  in  1  A valid.
- input_a_ack  out  1  adder ready to take A.
- input_b  in  32  operand B (binary32).
- input_b_stb  in  1  B valid.
- input_b_ack  out  1  adder ready to take B.
- output_z  out  32  sum (binary32).
- output_z_stb  out  1  sum valid.
- output_z_ack  in  1  consumer accepts sum.

## Operation
- States: GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z.
- GET_A: drive input_a_ack=1. On an edge with input_a_ack & input_a_stb, latch A, drop ack, and go to GET_B. GET_B does the same for B and goes to UNPACK.
- UNPACK: split each operand into sign, exponent (bias removed, e-127) and 24-bit significand. A normal number gets hidden bit 1. Exponent field 0 (zero or denormal) means exponent −126, hidden bit 0.
- SPECIAL: checks in priority order:
  - A or B is NaN → 0x7FC00000.
  - A inf & B inf with opposite signs → 0x7FC00000.
  - A inf → A's infinity; B inf → B's infinity.
  - A and B both zero → zero with sign = sA & sB.
  - A zero → B unchanged; B zero → A unchanged.
  - In every case above, go directly to PUT_Z. Otherwise go to ALIGN.
- Significands are carried as 27 bits: 24 bits plus guard, round and sticky. G, R and S are zero at unpack.
- ALIGN: each cycle, shift the smaller-exponent significand right 1 and increment its exponent. Bits shifted out OR into sticky. Leave when the exponents are equal. Equal exponents cost 1 cycle.
- ADD_0: equal signs add magnitudes. Different signs subtract the smaller magnitude from the larger, and the result takes the larger operand's sign. The sum is 28 bits wide. An exact zero difference gives +0.
- ADD_1: a carry-out shifts right 1 (lost bit ORs into sticky) and increments the exponent.
- NORM_1: while hidden bit = 0 and exponent > −126, shift left 1 and decrement the exponent, one per cycle.
- NORM_2: while exponent < −126, shift right 1 and increment the exponent (denormal result), one per cycle.
- ROUND: round to nearest, ties to even. Round up when G & (R | S | LSB). A mantissa overflow from rounding increments the exponent.
- PACK: assemble the result.
  - Exponent −126 with hidden bit 0 → field 0 (denormal or zero).
  - Exponent > 127 → ±infinity, mantissa 0.
- PUT_Z: drive output_z_stb=1 with output_z stable. On an edge with output_z_stb & output_z_ack, drop stb and return to GET_A.

## Timing
- rst=1 on an edge puts the FSM in GET_A and sets input_a_ack=0, input_b_ack=0, output_z_stb=0 and output_z=0. This applies in any state, including mid-computation; the in-flight operation is discarded.
- After reset release, input_a_ack rises 1 cycle after entering GET_A; with stb already high, A transfers on the next edge. GET_B behaves the same way, so each operand costs 2 cycles.
- Latency is data-dependent: 1 cycle each for UNPACK, SPECIAL, ADD_0, ADD_1, ROUND and PACK, plus 1 cycle per ALIGN/NORM shift (at least 1 each).
- Special cases skip straight from SPECIAL to PUT_Z.
- Acks are never high outside their GET state. output_z is constant while output_z_stb=1.
- If output_z_ack is never asserted, output_z_stb stays high indefinitely and no new operand is accepted.
- stb signals held high across results are consumed once per GET state.

## Test plan
- A=0xC14C51EC (−12.77), B=0x4206A2EB (33.6591), both stb=1 after reset, z_ack=0 → output_z=0x41A71CE0 (20.8891), output_z_stb stays 1, both acks stay 0.
- A=0x3F800000, B=0x3F800000 → 0x40000000. Then pulse z_ack → stb drops, FSM returns to GET_A and input_a_ack=1.
- A=0x7F800000, B=0xFF800000 → 0x7FC00000. A=0x7FC00000, B=0x3F800000 → 0x7FC00000.
- A=0x40400000, B=0xC0400000 → 0x00000000. A=0x80000000, B=0x80000000 → 0x80000000.
- A=0x7F7FFFFF, B=0x7F7FFFFF → 0x7F800000. A=0x00000001, B=0x00000001 → 0x00000002 (denormal). A=0x3F800000, B=0x33800000 → 0x3F800000 (tie, rounds to even).
- Assert rst during ALIGN → next cycle all outputs are 0 and the FSM is in GET_A. A fresh 1.0+1.0 then yields 0x40000000.
